// File: rtl/alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_arbiter
//  Description : Round-robin arbiter sharing one execution ALU between two
//                issue slots. It holds the operands in registers for a
//                per-class latency and returns the result and tag over a
//                valid/ready channel.
//                Optional macro DIV_ZERO_BYPASS_EN: a div-class op with
//                in2 == 0 returns the RISC-V divide-by-zero result directly.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_issue_arbiter #(
    parameter int TAG_W   = 4,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [4:0]       req0_aluop,
    input  logic [31:0]      req0_in1,
    input  logic [31:0]      req0_in2,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [4:0]       req1_aluop,
    input  logic [31:0]      req1_in1,
    input  logic [31:0]      req1_in2,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [4:0]       alu_op,
    output logic [31:0]      alu_in1,
    output logic [31:0]      alu_in2,
    input  logic [31:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_src,
    output logic             busy
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_CNT_W   = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_MUL_CNT = c_CNT_W'(MUL_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_CNT = c_CNT_W'(DIV_LAT - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               r_rr_ptr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_unsup;
    logic [4:0]         r_alu_op;
    logic [31:0]        r_alu_in1;
    logic [31:0]        r_alu_in2;
    logic [31:0]        r_rsp_result;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic               r_rsp_src;

    logic               w_idle;
    logic               w_grant;
    logic               w_accept;
    logic [4:0]         w_sel_op;
    logic [31:0]        w_sel_in1;
    logic [31:0]        w_sel_in2;
    logic [TAG_W-1:0]   w_sel_tag;
    logic               w_supported;
    logic               w_is_mul;
    logic               w_is_div;
    logic [c_CNT_W-1:0] w_load_cnt;
    logic               w_div_zero;
    logic [31:0]        w_div_zero_result;

    // A lone requester wins outright; rr_ptr only breaks ties.
    assign w_idle     = (r_state == c_ST_IDLE);
    assign w_grant    = (req0_valid & req1_valid) ? r_rr_ptr : req1_valid;
    assign req0_ready = w_idle & ~w_grant;
    assign req1_ready = w_idle &  w_grant;
    assign w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    assign w_sel_op  = w_grant ? req1_aluop : req0_aluop;
    assign w_sel_in1 = w_grant ? req1_in1   : req0_in1;
    assign w_sel_in2 = w_grant ? req1_in2   : req0_in2;
    assign w_sel_tag = w_grant ? req1_tag   : req0_tag;

    always_comb begin
        w_supported = 1'b0;
        w_is_mul    = 1'b0;
        w_is_div    = 1'b0;
        case (w_sel_op) inside
            [5'd0:5'd9]: w_supported = 1'b1;
            5'd16, 5'd17, 5'd18, 5'd22: begin
                w_supported = 1'b1;
                w_is_mul    = 1'b1;
            end
            5'd24, 5'd26, 5'd28, 5'd30: begin
                w_supported = 1'b1;
                w_is_div    = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_load_cnt = w_is_div ? c_DIV_CNT : (w_is_mul ? c_MUL_CNT : '0);

`ifdef DIV_ZERO_BYPASS_EN
    // div/divu return all ones, rem/remu return the dividend (aluop bit 2 selects rem).
    assign w_div_zero        = w_is_div & (w_sel_in2 == 32'd0);
    assign w_div_zero_result = w_sel_op[2] ? w_sel_in1 : 32'hFFFF_FFFF;
`else
    assign w_div_zero        = 1'b0;
    assign w_div_zero_result = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_div_zero ? c_ST_RESP : c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                if (r_cnt == '0) begin
                    w_next_state = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= 1'b0;
            r_cnt        <= '0;
            r_unsup      <= 1'b0;
            r_alu_op     <= 5'd0;
            r_alu_in1    <= 32'd0;
            r_alu_in2    <= 32'd0;
            r_rsp_result <= 32'd0;
            r_rsp_tag    <= '0;
            r_rsp_src    <= 1'b0;
        end else if (w_accept) begin
            r_alu_op  <= w_sel_op;
            r_alu_in1 <= w_sel_in1;
            r_alu_in2 <= w_sel_in2;
            r_rsp_tag <= w_sel_tag;
            r_rsp_src <= w_grant;
            r_rr_ptr  <= ~w_grant;
            r_cnt     <= w_load_cnt;
            r_unsup   <= ~w_supported;
            if (w_div_zero) begin
                r_rsp_result <= w_div_zero_result;
            end
        end else if (r_state == c_ST_EXEC) begin
            if (r_cnt == '0) begin
                r_rsp_result <= r_unsup ? 32'd0 : alu_result;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign alu_op     = r_alu_op;
    assign alu_in1    = r_alu_in1;
    assign alu_in2    = r_alu_in2;
    assign rsp_valid  = (r_state == c_ST_RESP);
    assign rsp_result = r_rsp_result;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_src    = r_rsp_src;
    assign busy       = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_arbiter
//  Description : Directed self-checking bench for alu_issue_arbiter with a
//                behavioural ALU attached.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_issue_arbiter;

    localparam int c_TAG_W   = 4;
    localparam int c_MUL_LAT = 2;
    localparam int c_DIV_LAT = 4;

    logic               clk;
    logic               rst;
    logic               req0_valid, req0_ready;
    logic [4:0]         req0_aluop;
    logic [31:0]        req0_in1, req0_in2;
    logic [c_TAG_W-1:0] req0_tag;
    logic               req1_valid, req1_ready;
    logic [4:0]         req1_aluop;
    logic [31:0]        req1_in1, req1_in2;
    logic [c_TAG_W-1:0] req1_tag;
    logic [4:0]         alu_op;
    logic [31:0]        alu_in1, alu_in2, alu_result;
    logic               rsp_valid, rsp_ready;
    logic [31:0]        rsp_result;
    logic [c_TAG_W-1:0] rsp_tag;
    logic               rsp_src;
    logic               busy;

    int checks = 0;
    int errors = 0;

    alu_issue_arbiter #(
        .TAG_W  (c_TAG_W),
        .MUL_LAT(c_MUL_LAT),
        .DIV_LAT(c_DIV_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_aluop(req0_aluop),
        .req0_in1  (req0_in1),
        .req0_in2  (req0_in2),
        .req0_tag  (req0_tag),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_aluop(req1_aluop),
        .req1_in1  (req1_in1),
        .req1_in2  (req1_in2),
        .req1_tag  (req1_tag),
        .alu_op    (alu_op),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_result(alu_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_tag   (rsp_tag),
        .rsp_src   (rsp_src),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; unmodelled opcodes return a marker value.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        case (alu_op)
            5'd0:  alu_result = alu_in1 + alu_in2;
            5'd1:  alu_result = alu_in1 - alu_in2;
            5'd5:  alu_result = alu_in1 ^ alu_in2;
            5'd16, 5'd17, 5'd18, 5'd22: alu_result = alu_in1 * alu_in2;
            5'd24: alu_result = (alu_in2 == 0) ? 32'hFFFF_FFFF : 32'($signed(alu_in1) / $signed(alu_in2));
            5'd26: alu_result = (alu_in2 == 0) ? 32'hFFFF_FFFF : alu_in1 / alu_in2;
            5'd28: alu_result = (alu_in2 == 0) ? alu_in1 : 32'($signed(alu_in1) % $signed(alu_in2));
            5'd30: alu_result = (alu_in2 == 0) ? alu_in1 : alu_in1 % alu_in2;
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_aluop = 5'd0; req0_in1 = 32'd0; req0_in2 = 32'd0; req0_tag = '0;
        req1_valid = 1'b0; req1_aluop = 5'd0; req1_in1 = 32'd0; req1_in2 = 32'd0; req1_tag = '0;
        tick();
        tick();
        chk("rst_alu_op",  32'(alu_op), 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_alu_in2", alu_in2, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_rsp_src", 32'(rsp_src), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // 1) lone req0 add 5+7 tag 3
        req0_valid = 1'b1; req0_aluop = 5'd0; req0_in1 = 32'd5; req0_in2 = 32'd7; req0_tag = 4'd3;
        #1;
        chk("t1_req0_ready", 32'(req0_ready), 32'd1);
        chk("t1_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("t1_busy_exec", 32'(busy), 32'd1);
        chk("t1_valid_k1", 32'(rsp_valid), 32'd0);
        chk("t1_alu_in1", alu_in1, 32'd5);
        chk("t1_alu_in2", alu_in2, 32'd7);
        tick();
        chk("t1_valid_k2", 32'(rsp_valid), 32'd1);
        chk("t1_result", rsp_result, 32'd12);
        chk("t1_tag", 32'(rsp_tag), 32'd3);
        chk("t1_src", 32'(rsp_src), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t1_idle_valid", 32'(rsp_valid), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // 2) contention from reset: req0 sub first, then req1 xor
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_aluop = 5'd1; req0_in1 = 32'd10;  req0_in2 = 32'd3;  req0_tag = 4'd1;
        req1_valid = 1'b1; req1_aluop = 5'd5; req1_in1 = 32'hF0; req1_in2 = 32'h0F; req1_tag = 4'd2;
        #1;
        chk("t2_req0_ready", 32'(req0_ready), 32'd1);
        chk("t2_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("t2_req1_stall_exec", 32'(req1_ready), 32'd0);
        tick();
        chk("t2_res0", rsp_result, 32'd7);
        chk("t2_src0", 32'(rsp_src), 32'd0);
        chk("t2_tag0", 32'(rsp_tag), 32'd1);
        chk("t2_req1_stall_resp", 32'(req1_ready), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t2_req1_ready", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("t2_res1", rsp_result, 32'hFF);
        chk("t2_src1", 32'(rsp_src), 32'd1);
        chk("t2_tag1", 32'(rsp_tag), 32'd2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        // rr_ptr back to 0 after serving slot 1; keep both valid across two grants
        req0_valid = 1'b1; req0_aluop = 5'd0; req0_in1 = 32'd1; req0_in2 = 32'd1; req0_tag = 4'd4;
        req1_valid = 1'b1; req1_aluop = 5'd0; req1_in1 = 32'd2; req1_in2 = 32'd2; req1_tag = 4'd5;
        #1;
        chk("t2_rr_req0_ready", 32'(req0_ready), 32'd1);
        tick();
        tick();
        chk("t2_rr_res0", rsp_result, 32'd2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t2_rr_req1_ready", 32'(req1_ready), 32'd1);
        chk("t2_rr_req0_blocked", 32'(req0_ready), 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("t2_rr_res1", rsp_result, 32'd4);
        chk("t2_rr_src1", 32'(rsp_src), 32'd1);
        chk("t2_rr_tag1", 32'(rsp_tag), 32'd5);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 3) signed div -20/3, DIV_LAT cycles with stable operands
        req0_valid = 1'b1; req0_aluop = 5'd24; req0_in1 = 32'hFFFF_FFEC; req0_in2 = 32'd3; req0_tag = 4'd6;
        tick();
        req0_valid = 1'b0;
        chk("t3_alu_op", 32'(alu_op), 32'd24);
        for (int i = 0; i < c_DIV_LAT; i++) begin
            chk("t3_in1_stable", alu_in1, 32'hFFFF_FFEC);
            chk("t3_in2_stable", alu_in2, 32'd3);
            chk("t3_not_valid", 32'(rsp_valid), 32'd0);
            if (i < c_DIV_LAT - 1) tick();
        end
        tick();
        chk("t3_valid", 32'(rsp_valid), 32'd1);
        chk("t3_result", rsp_result, 32'hFFFF_FFFA);

        // 4) back-pressure for three cycles with a pending req1
        req1_valid = 1'b1; req1_aluop = 5'd0; req1_in1 = 32'd9; req1_in2 = 32'd9; req1_tag = 4'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t4_hold_result", rsp_result, 32'hFFFF_FFFA);
            chk("t4_hold_tag", 32'(rsp_tag), 32'd6);
            chk("t4_req0_ready", 32'(req0_ready), 32'd0);
            chk("t4_req1_ready", 32'(req1_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t4_idle_valid", 32'(rsp_valid), 32'd0);
        chk("t4_idle_busy", 32'(busy), 32'd0);
        req1_valid = 1'b0;

        // 5) reset during a mul, then a fresh mul
        tick();
        req1_valid = 1'b1; req1_aluop = 5'd22; req1_in1 = 32'd6; req1_in2 = 32'd7; req1_tag = 4'd7;
        tick();
        req1_valid = 1'b0;
        chk("t5_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_alu_op", 32'(alu_op), 32'd0);
        chk("t5_rst_alu_in1", alu_in1, 32'd0);
        chk("t5_rst_result", rsp_result, 32'd0);
        chk("t5_rst_tag", 32'(rsp_tag), 32'd0);
        chk("t5_rst_src", 32'(rsp_src), 32'd0);
        req0_valid = 1'b1; req0_aluop = 5'd16; req0_in1 = 32'd3; req0_in2 = 32'd4; req0_tag = 4'd8;
        #1;
        chk("t5_new_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("t5_mul_not_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("t5_mul_valid", 32'(rsp_valid), 32'd1);
        chk("t5_mul_result", rsp_result, 32'd12);
        chk("t5_mul_tag", 32'(rsp_tag), 32'd8);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 6) remu by zero; lone req0 while rr_ptr favours slot 1
        req0_valid = 1'b1; req0_aluop = 5'd30; req0_in1 = 32'h1234; req0_in2 = 32'd0; req0_tag = 4'd9;
        #1;
        chk("t6_lone_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
        chk("t6_bypass_valid", 32'(rsp_valid), 32'd1);
`else
        for (int i = 0; i < c_DIV_LAT; i++) begin
            chk("t6_not_valid", 32'(rsp_valid), 32'd0);
            tick();
        end
        chk("t6_valid", 32'(rsp_valid), 32'd1);
`endif
        chk("t6_result", rsp_result, 32'h1234);
        chk("t6_tag", 32'(rsp_tag), 32'd9);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // unsupported opcode returns zero after one EXEC cycle
        req1_valid = 1'b1; req1_aluop = 5'd25; req1_in1 = 32'd1; req1_in2 = 32'd1; req1_tag = 4'd10;
        tick();
        req1_valid = 1'b0;
        tick();
        chk("t7_valid", 32'(rsp_valid), 32'd1);
        chk("t7_result", rsp_result, 32'd0);
        chk("t7_src", 32'(rsp_src), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t7_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
